// File: rtl/store_control_pkg.sv
// Shared definitions for the store stage: instruction opcodes, field positions
// and the AXI encodings the store burst uses.
package store_control_pkg;

  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpExec  = 3'b010;
  localparam logic [2:0] OpAct   = 3'b011;
  localparam logic [2:0] OpStore = 3'b100;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 29;
  localparam int unsigned BaseMsb   = 28;
  localparam int unsigned BaseLsb   = 11;
  localparam int unsigned LenMsb    = 10;
  localparam int unsigned LenLsb    = 3;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  function automatic logic [2:0] instr_opcode(input logic [31:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

  function automatic logic [17:0] instr_base(input logic [31:0] instr);
    return instr[BaseMsb:BaseLsb];
  endfunction

  function automatic logic [7:0] instr_len(input logic [31:0] instr);
    return instr[LenMsb:LenLsb];
  endfunction

endpackage

// File: rtl/store_control.sv
// Store stage: pops store instructions and streams len+1 activation words to
// memory as one AXI4 INCR write burst, then waits for the write response.
module store_control
  import store_control_pkg::*;
#(
  parameter int unsigned AXI_WIDTH_ID = 4,
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned AXI_WIDTH_DA = 32,
  parameter int unsigned AXI_WIDTH_DS = AXI_WIDTH_DA / 8,
  parameter logic [2:0]  STORE_OPCODE = OpStore
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_store_instruction_fifo_empty,
  input  logic [31:0]             i_store_instruction_data,
  output logic                    o_store_instruction_fifo_rd_en,
  input  logic                    i_activation_out_fifo_empty,
  input  logic [AXI_WIDTH_DA-1:0] i_activation_out_fifo_data,
  output logic                    o_activation_out_fifo_rd_en,
  output logic [AXI_WIDTH_ID-1:0] o_m_axi_awid,
  output logic [AXI_WIDTH_AD-1:0] o_m_axi_awaddr,
  output logic [7:0]              o_m_axi_awlen,
  output logic [2:0]              o_m_axi_awsize,
  output logic [1:0]              o_m_axi_awburst,
  output logic                    o_m_axi_awvalid,
  input  logic                    i_m_axi_awready,
  output logic [AXI_WIDTH_DA-1:0] o_m_axi_wdata,
  output logic [AXI_WIDTH_DS-1:0] o_m_axi_wstrb,
  output logic                    o_m_axi_wlast,
  output logic                    o_m_axi_wvalid,
  input  logic                    i_m_axi_wready,
  input  logic [1:0]              i_m_axi_bresp,
  input  logic                    i_m_axi_bvalid,
  output logic                    o_m_axi_bready,
  output logic                    o_store_idle,
  output logic                    o_store_done,
  output logic                    o_store_error
);

  localparam int unsigned AddrShift = $clog2(AXI_WIDTH_DS);

  localparam logic [3:0] StIdle = 4'b0001;
  localparam logic [3:0] StAddr = 4'b0010;
  localparam logic [3:0] StData = 4'b0100;
  localparam logic [3:0] StResp = 4'b1000;

  logic [3:0]  state_q, state_d;
  logic [17:0] base_q, base_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        awvalid_q, awvalid_d;
  logic        error_q, error_d;

  logic is_idle, is_data, is_resp;
  logic instr_pop, is_store, store_accept;
  logic w_valid, w_last, beat, b_hs;
  logic unused_instr_bits;

  assign unused_instr_bits = ^i_store_instruction_data[2:0];

  always_comb begin
    is_idle      = (state_q == StIdle);
    is_data      = (state_q == StData);
    is_resp      = (state_q == StResp);
    instr_pop    = is_idle && !i_store_instruction_fifo_empty;
    is_store     = (instr_opcode(i_store_instruction_data) == STORE_OPCODE);
    store_accept = instr_pop && is_store;
    // wvalid depends only on data availability, never on wready
    w_valid      = is_data && !i_activation_out_fifo_empty;
    w_last       = is_data && (beat_cnt_q == 8'd0);
    beat         = w_valid && i_m_axi_wready;
    b_hs         = is_resp && i_m_axi_bvalid;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    awvalid_d  = awvalid_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        if (store_accept) begin
          base_d     = instr_base(i_store_instruction_data);
          len_d      = instr_len(i_store_instruction_data);
          beat_cnt_d = instr_len(i_store_instruction_data);
          awvalid_d  = 1'b1;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (awvalid_q && i_m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (w_last) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (i_m_axi_bvalid) begin
          if (i_m_axi_bresp != AxiRespOkay) begin
            error_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        awvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      awvalid_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      awvalid_q  <= awvalid_d;
      error_q    <= error_d;
    end
  end

  assign o_store_instruction_fifo_rd_en = instr_pop;
  assign o_activation_out_fifo_rd_en    = beat;

  assign o_m_axi_awid    = '0;
  assign o_m_axi_awaddr  = AXI_WIDTH_AD'(base_q) << AddrShift;
  assign o_m_axi_awlen   = len_q;
  assign o_m_axi_awsize  = 3'(AddrShift);
  assign o_m_axi_awburst = AxiBurstIncr;
  assign o_m_axi_awvalid = awvalid_q;

  assign o_m_axi_wdata  = i_activation_out_fifo_data;
  assign o_m_axi_wstrb  = '1;
  assign o_m_axi_wlast  = w_last;
  assign o_m_axi_wvalid = w_valid;

  assign o_m_axi_bready = is_resp;
  assign o_store_idle   = is_idle;
  assign o_store_done   = b_hs;
  assign o_store_error  = error_q;

endmodule

// File: tb/tb_store_control.sv
// Directed bench for store_control: FIFO and AXI slave models driven from a
// vector table, plus hand-written reset and power-up sequences.
module tb_store_control;

  logic        clk;
  logic        rst;
  logic        instr_empty;
  logic [31:0] instr_data;
  logic        instr_rd_en;
  logic        act_empty;
  logic [31:0] act_data;
  logic        act_rd_en;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        store_idle;
  logic        store_done;
  logic        store_error;

  store_control dut (
    .clk                            (clk),
    .rst                            (rst),
    .i_store_instruction_fifo_empty (instr_empty),
    .i_store_instruction_data       (instr_data),
    .o_store_instruction_fifo_rd_en (instr_rd_en),
    .i_activation_out_fifo_empty    (act_empty),
    .i_activation_out_fifo_data     (act_data),
    .o_activation_out_fifo_rd_en    (act_rd_en),
    .o_m_axi_awid                   (awid),
    .o_m_axi_awaddr                 (awaddr),
    .o_m_axi_awlen                  (awlen),
    .o_m_axi_awsize                 (awsize),
    .o_m_axi_awburst                (awburst),
    .o_m_axi_awvalid                (awvalid),
    .i_m_axi_awready                (awready),
    .o_m_axi_wdata                  (wdata),
    .o_m_axi_wstrb                  (wstrb),
    .o_m_axi_wlast                  (wlast),
    .o_m_axi_wvalid                 (wvalid),
    .i_m_axi_wready                 (wready),
    .i_m_axi_bresp                  (bresp),
    .i_m_axi_bvalid                 (bvalid),
    .o_m_axi_bready                 (bready),
    .o_store_idle                   (store_idle),
    .o_store_done                   (store_done),
    .o_store_error                  (store_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [17:0] base;
    logic [7:0]  len;
    logic [1:0]  bresp;
    bit          bp;
    int          starve;
    logic [31:0] exp_addr;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];

  int n_ipop, n_dpop, n_aw, n_wlast, last_wlast_idx, n_done;
  int stab_err, starve_viol, cyc, pop_cyc, done_cyc;
  int starve_at, starve_left;
  bit bp;
  logic [1:0]  cur_bresp;
  logic [31:0] got_addr;
  logic [7:0]  got_len;
  logic        prev_aw_stall, prev_w_stall;
  logic [31:0] prev_awaddr, prev_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    instr_empty = (iq.size() == 0);
    instr_data  = instr_empty ? 32'h0 : iq[0];
    act_empty   = (dq.size() == 0) || (starve_left > 0);
    act_data    = (dq.size() == 0) ? 32'h0 : dq[0];
    awready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    wready      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bvalid      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bresp       = cur_bresp;
  endtask

  task automatic clear_mon();
    n_ipop = 0; n_dpop = 0; n_aw = 0; n_wlast = 0; last_wlast_idx = -1; n_done = 0;
    stab_err = 0; starve_viol = 0; pop_cyc = 0; done_cyc = 0;
    got_addr = '0; got_len = '0;
    prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    got_w.delete();
  endtask

  // Sample at the falling edge, apply FIFO pops and new inputs after the rising edge.
  task automatic cycle();
    logic ipop, dpop;
    logic [31:0] tmp;
    @(negedge clk);
    cyc++;
    if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) stab_err++;
    if (prev_w_stall && (!wvalid || wdata !== prev_wdata)) stab_err++;
    prev_aw_stall = awvalid && !awready;
    prev_awaddr   = awaddr;
    prev_w_stall  = wvalid && !wready;
    prev_wdata    = wdata;
    if (instr_rd_en) begin n_ipop++; pop_cyc = cyc; end
    if (act_rd_en) n_dpop++;
    if (awvalid && awready) begin n_aw++; got_addr = awaddr; got_len = awlen; end
    if (wvalid && wready) begin
      got_w.push_back(wdata);
      if (wlast) begin n_wlast++; last_wlast_idx = got_w.size() - 1; end
    end
    if (starve_left > 0 && (wvalid || act_rd_en)) starve_viol++;
    if (store_done) begin n_done++; done_cyc = cyc; end
    ipop = instr_rd_en;
    dpop = act_rd_en;
    @(posedge clk);
    #1;
    if (ipop && iq.size() > 0) tmp = iq.pop_front();
    if (dpop && dq.size() > 0) tmp = dq.pop_front();
    if (starve_left > 0) starve_left--;
    if (starve_at >= 0 && got_w.size() == starve_at) begin
      starve_left = 5;
      starve_at   = -1;
    end
    drive_inputs();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int mism;
    clear_mon();
    exp_w.delete();
    cur_bresp = v.bresp;
    bp        = v.bp;
    starve_at = v.starve;
    iq.push_back({v.op, v.base, v.len, 3'b101});
    for (int b = 0; b < v.exp_beats; b++) begin
      dq.push_back(32'hA000_0000 | (idx << 16) | b);
      exp_w.push_back(32'hA000_0000 | (idx << 16) | b);
    end
    drive_inputs();
    if (v.exp_beats > 0) begin
      for (int c = 0; c < 3000 && n_done == 0; c++) cycle();
      cycle();
      chk("instr_pops", n_ipop, 1);
      chk("aw_handshakes", n_aw, 1);
      chk("awaddr", got_addr, v.exp_addr);
      chk("awlen", got_len, v.len);
      chk("beats", got_w.size(), v.exp_beats);
      chk("data_pops", n_dpop, v.exp_beats);
      mism = 0;
      for (int b = 0; b < got_w.size() && b < exp_w.size(); b++)
        if (got_w[b] !== exp_w[b]) mism++;
      chk("wdata_order", mism, 0);
      chk("wlast_count", n_wlast, 1);
      chk("wlast_pos", last_wlast_idx, v.exp_beats - 1);
      chk("done_pulses", n_done, 1);
      chk("store_error", store_error, v.exp_err);
      chk("stable_while_stalled", stab_err, 0);
      chk("starve_no_valid", starve_viol, 0);
      chk("idle_after", store_idle, 1'b1);
      if (!v.bp && v.starve < 0) chk("pop_to_done", done_cyc - pop_cyc, v.len + 3);
    end else begin
      for (int c = 0; c < 4; c++) cycle();
      chk("discard_pop", n_ipop, 1);
      chk("discard_no_aw", n_aw, 0);
      chk("discard_no_w", got_w.size(), 0);
      chk("discard_no_data_pop", n_dpop, 0);
      chk("discard_no_done", n_done, 0);
      chk("discard_idle", store_idle, 1'b1);
    end
    bp = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'b100, 18'h00010, 8'd3,   2'b00, 1'b0, -1, 32'h0000_0040, 4,   1'b0};
    vecs[1] = '{3'b011, 18'h00005, 8'd2,   2'b00, 1'b0, -1, 32'h0,         0,   1'b0};
    vecs[2] = '{3'b100, 18'h00021, 8'd0,   2'b00, 1'b0, -1, 32'h0000_0084, 1,   1'b0};
    vecs[3] = '{3'b100, 18'h00100, 8'd7,   2'b00, 1'b0,  2, 32'h0000_0400, 8,   1'b0};
    vecs[4] = '{3'b100, 18'h00123, 8'd5,   2'b00, 1'b1, -1, 32'h0000_048C, 6,   1'b0};
    vecs[5] = '{3'b100, 18'h3FFFF, 8'd0,   2'b00, 1'b0, -1, 32'h000F_FFFC, 1,   1'b0};
    vecs[6] = '{3'b100, 18'h00200, 8'd255, 2'b00, 1'b0, -1, 32'h0000_0800, 256, 1'b0};
    vecs[7] = '{3'b100, 18'h00007, 8'd1,   2'b10, 1'b0, -1, 32'h0000_001C, 2,   1'b1};
    vecs[8] = '{3'b100, 18'h00008, 8'd2,   2'b00, 1'b1, -1, 32'h0000_0020, 3,   1'b1};
    vecs[9] = '{3'b001, 18'h00009, 8'd4,   2'b00, 1'b0, -1, 32'h0,         0,   1'b1};

    cyc = 0; bp = 1'b0; cur_bresp = 2'b00; starve_at = -1; starve_left = 0;
    clear_mon();
    rst = 1'b1;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Power-up: idle with empty FIFOs, no pops, fixed AXI fields.
    for (int c = 0; c < 3; c++) cycle();
    chk("reset_idle", store_idle, 1'b1);
    chk("reset_awvalid", awvalid, 1'b0);
    chk("reset_wvalid", wvalid, 1'b0);
    chk("reset_bready", bready, 1'b0);
    chk("reset_done", store_done, 1'b0);
    chk("reset_error", store_error, 1'b0);
    chk("reset_no_pops", n_ipop + n_dpop, 0);
    chk("awsize", awsize, 3'd2);
    chk("awburst", awburst, 2'b01);
    chk("awid", awid, 4'd0);
    chk("wstrb", wstrb, 4'hF);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset during beat 3 of a 16-beat burst.
    clear_mon();
    exp_w.delete();
    cur_bresp = 2'b00;
    iq.push_back({3'b100, 18'h00040, 8'd15, 3'b000});
    for (int b = 0; b < 16; b++) dq.push_back(32'hB000_0000 | b);
    drive_inputs();
    for (int c = 0; c < 100 && got_w.size() < 2; c++) cycle();
    #2;
    chk("wvalid_before_rst", wvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_idle", store_idle, 1'b1);
    chk("rst_data_rd_en", act_rd_en, 1'b0);
    chk("rst_error_cleared", store_error, 1'b0);
    clear_mon();
    for (int c = 0; c < 3; c++) cycle();
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("post_rst_no_pops", n_dpop + n_ipop, 0);
    chk("post_rst_no_aw", n_aw, 0);
    chk("post_rst_idle", store_idle, 1'b1);
    dq.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
